keynsham_copy_master: RTL and testbench
=======================================

// Module: keynsham_copy_master
// PURPOSE
//  Bus initiator: copies LEN 32-bit words from SRC to DST over the keynsham data bus.
//  Issues access/cs/addr requests, waits for the single-cycle ack and drives write data/bytesel.
//  Boot code uses it to move images from bootrom/flash into RAM.
//  Sits beside the CPU data port behind the bus arbiter.
// PARAMETERS
//  ADDR_WIDTH  30  word-address width of m_addr; SRC/DST wrap modulo 2^ADDR_WIDTH
//  LEN_WIDTH   16  width of word count
//  TIMEOUT     64  cycles waiting for m_ack before abort (>=2)
// PORTS
//  clk          in   1           system clock
//  rst_n        in   1           asynchronous, active-low reset
//  start        in   1           one-cycle pulse; latches src/dst/len; ignored while busy
//  src          in   ADDR_WIDTH  source word address
//  dst          in   ADDR_WIDTH  destination word address
//  len          in   LEN_WIDTH   number of words to copy
//  busy         out  1           high from cycle after accepted start until done/error
//  done         out  1           one-cycle pulse: copy finished OK
//  error        out  1           one-cycle pulse: ack timeout, copy aborted
//  m_access     out  1           bus request; registered
//  m_cs         out  1           equal to m_access (arbiter performs decode)
//  m_addr       out  ADDR_WIDTH  word address of current transfer
//  m_wr_en      out  1           1 = write, 0 = read; valid with m_access
//  m_bytesel    out  4           4'b1111 during every access, else 0
//  m_wr_val     out  32          write data (captured read word)
//  m_data       in   32          read data; valid only when m_ack=1 (responders drive 0 otherwise)
//  m_ack        in   1           single-cycle completion from responder
// BEHAVIOUR
//  - Reset (async assert): state IDLE; all outputs 0; counters and captured data 0.
//  - FSM: IDLE -> RD_REQ -> RD_GAP -> WR_REQ -> WR_GAP -> RD_REQ ... ; ERR; FIN.
//  - IDLE: on start: len==0 -> FIN; else latch src/dst/len -> RD_REQ. busy=1 next cycle.
//  - RD_REQ: m_access=1, m_wr_en=0, m_addr=cur_src. On m_ack: capture m_data -> m_wr_val,
//    -> RD_GAP. Timeout counter reset on entry.
//  - *_GAP: one turnaround cycle, m_access=0; m_ack ignored (registered-ack responders
//    re-ack once when access was still high on their sampling edge).
//  - RD_GAP -> WR_REQ. WR_REQ: m_access=1, m_wr_en=1, m_addr=cur_dst, m_wr_val held.
//    On m_ack -> WR_GAP; cur_src++, cur_dst++, remaining--.
//  - WR_GAP: remaining==0 -> FIN, else RD_REQ.
//  - FIN: done=1 for one cycle, busy drops same cycle as done -> IDLE.
//  - Timeout: in *_REQ, counter increments each cycle without m_ack; reaching TIMEOUT-1 with
//    no ack -> ERR: m_access=0, error=1 one cycle, busy=0 -> IDLE. Ack on the limit cycle wins.
//  - Throughput: 3 cycles/transaction minimum with 1-cycle-latency responder (6/word).
//  - m_ack in IDLE/GAP/FIN/ERR: ignored, no state effect.
//  - start during busy: ignored, no latch. start same cycle as done/error: ignored.
//  - Address increments wrap modulo 2^ADDR_WIDTH; overlapping src/dst not detected (word
//    ascending order defined).
//  - Reset mid-transfer: immediate abort, m_access=0 asynchronously, no done/error pulse.
// STRUCTURE
//  - keynsham_copy_defines.vh: state encodings, BYTESEL_ALL=4'b1111.
//  - Sub-module keynsham_ack_timer: loadable TIMEOUT counter with clear/expire outputs.
//  - Top: FSM, address/length counters, read-data capture register.
// TESTING (bench with 1-cycle registered-ack responder model + RAM model)
//  - len=4, src=0x10, dst=0x200, ROM words 0xA0..0xA3 -> RAM[0x200..0x203]=0xA0..0xA3;
//    done pulse 24 cycles after start; 4 reads, 4 writes, bytesel=4'hF on each.
//  - len=0 -> done 1 cycle later, m_access never asserted, busy pulse-free or one cycle.
//  - Responder never acks write, TIMEOUT=64 -> error pulse after 64 cycles in WR_REQ,
//    m_access low next cycle, RAM untouched, no done.
//  - Responder acks after 5 wait cycles; spurious ack in GAP -> ignored, counts unchanged.
//  - src=2^30-1, len=2 -> second read at addr 0 (wrap); start pulse during busy ignored.
//  - rst_n low mid WR_REQ -> all outputs 0 immediately; new start after release copies cleanly.

Source files
------------

// File: rtl/keynsham_copy_pkg.sv
// rtl/keynsham_copy_pkg.sv - shared state encoding and bus constants for the copy master
package keynsham_copy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_GAP = 3'd2,
        ST_WR_REQ = 3'd3,
        ST_WR_GAP = 3'd4,
        ST_FIN    = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [3:0] BYTESEL_ALL = 4'b1111;

    function automatic logic is_req(input state_t s);
        return (s == ST_RD_REQ) || (s == ST_WR_REQ);
    endfunction

endpackage

// File: rtl/keynsham_ack_timer.sv
// rtl/keynsham_ack_timer.sv - counts un-acked request cycles and flags the abort limit
module keynsham_ack_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    // Holds at the limit; the FSM leaves the request state on that cycle anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keynsham_copy_master.sv
// rtl/keynsham_copy_master.sv - word copy initiator: read SRC, write DST, LEN times over the keynsham bus
module keynsham_copy_master
    import keynsham_copy_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int LEN_WIDTH  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  m_access,
    output logic                  m_cs,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_wr_en,
    output logic [3:0]            m_bytesel,
    output logic [31:0]           m_wr_val,
    input  logic [31:0]           m_data,
    input  logic                  m_ack
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [31:0]           wr_val_q, wr_val_d;
    logic                  access_q, access_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  expired;

    // Timer runs only while a request is outstanding and un-acked.
    keynsham_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!is_req(state_q) || m_ack),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        wr_val_d = wr_val_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        src_d   = src;
                        dst_d   = dst;
                        rem_d   = len;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (m_ack) begin
                    wr_val_d = m_data;
                    state_d  = ST_RD_GAP;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_RD_GAP: state_d = ST_WR_REQ;
            ST_WR_REQ: begin
                if (m_ack) begin
                    src_d   = src_q + ADDR_WIDTH'(1);
                    dst_d   = dst_q + ADDR_WIDTH'(1);
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    state_d = ST_WR_GAP;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_WR_GAP: state_d = (rem_q == '0) ? ST_FIN : ST_RD_REQ;
            ST_FIN:    state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        access_d = is_req(state_d);
        busy_d   = access_d || (state_d == ST_RD_GAP) || (state_d == ST_WR_GAP);
        done_d   = (state_d == ST_FIN);
        error_d  = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            wr_val_q <= '0;
            access_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            wr_val_q <= wr_val_d;
            access_q <= access_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign m_access  = access_q;
    assign m_cs      = access_q;
    assign m_wr_en   = access_q && (state_q == ST_WR_REQ);
    assign m_addr    = (state_q == ST_RD_REQ) ? src_q :
                       (state_q == ST_WR_REQ) ? dst_q : '0;
    assign m_bytesel = access_q ? BYTESEL_ALL : 4'b0000;
    assign m_wr_val  = wr_val_q;

endmodule

// File: tb/tb_keynsham_copy_master.sv
// tb/tb_keynsham_copy_master.sv - randomized and directed bench with RAM/responder and transaction model
module tb_keynsham_copy_master;

    localparam int AW = 30;
    localparam int LW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src, dst;
    logic [LW-1:0] len;
    logic          busy, done, error;
    logic          m_access, m_cs, m_wr_en, m_ack;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_bytesel;
    logic [31:0]   m_wr_val, m_data;

    always #5 clk = ~clk;

    keynsham_copy_master #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .error(error),
        .m_access(m_access), .m_cs(m_cs), .m_addr(m_addr), .m_wr_en(m_wr_en),
        .m_bytesel(m_bytesel), .m_wr_val(m_wr_val), .m_data(m_data), .m_ack(m_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory seen by the responder (ram) and by the reference model (mdl); same default contents.
    logic [31:0] ram [logic [AW-1:0]];
    logic [31:0] mdl [logic [AW-1:0]];

    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction
    function automatic logic [31:0] ram_rd(input logic [AW-1:0] a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction
    function automatic logic [31:0] mdl_rd(input logic [AW-1:0] a);
        return mdl.exists(a) ? mdl[a] : init_word(a);
    endfunction

    // Registered-ack responder: acks once access has been seen for wait+1 cycles (wait<0: never).
    int          wait_rd = 0;
    int          wait_wr = 0;
    bit          spur = 1'b0;
    int          acc_run = 0;
    logic        nxt_ack;
    logic [31:0] nxt_data;

    initial begin
        int w;
        m_ack  = 1'b0;
        m_data = 32'h0;
        forever begin
            @(negedge clk);
            nxt_ack  = 1'b0;
            nxt_data = 32'h0;
            if (!rst_n) begin
                acc_run = 0;
            end else if (m_access) begin
                acc_run++;
                w = m_wr_en ? wait_wr : wait_rd;
                if (w >= 0 && acc_run >= w + 1) begin
                    nxt_ack = 1'b1;
                    if (m_wr_en) ram[m_addr] = m_wr_val;
                    else         nxt_data = ram_rd(m_addr);
                end
            end else begin
                acc_run = 0;
                nxt_ack = spur;
            end
            @(posedge clk);
            #1;
            m_ack  = nxt_ack;
            m_data = nxt_data;
        end
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } txn_t;

    txn_t          exp_q[$];
    logic [AW-1:0] rd_log[$];
    int            n_rd = 0;
    int            n_wr = 0;
    bit            active = 1'b0;

    always @(negedge clk) begin : cmp
        txn_t t;
        if (rst_n) begin
            chk(m_cs == m_access, "cs_eq_access", m_cs, m_access);
            chk(m_bytesel == (m_access ? 4'hF : 4'h0), "bytesel", m_bytesel, {m_access, m_access, m_access, m_access});
            if (active)
                chk(busy == !(done || error), "busy_vs_pulse", {busy, done, error}, {!(done || error), done, error});
            else
                chk(!busy && !done && !error && !m_access, "idle_quiet", {busy, done, error, m_access}, 4'h0);
            if (m_access && m_ack) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_txn", {m_wr_en, m_addr}, 0);
                end else begin
                    t = exp_q.pop_front();
                    chk(m_wr_en == t.wr && m_addr == t.addr, "txn_kind_addr", {m_wr_en, m_addr}, {t.wr, t.addr});
                    if (t.wr) chk(m_wr_val == t.data, "wr_data", m_wr_val, t.data);
                    if (m_wr_en) n_wr++;
                    else begin
                        n_rd++;
                        rd_log.push_back(m_addr);
                    end
                end
            end
        end
    end

    int lat, run_len;
    bit got_done, got_err, got_acc;

    task automatic wait_end(input bit inj);
        lat = 0; run_len = 0; got_done = 0; got_err = 0; got_acc = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (done || error) begin
                got_done = done; got_err = error; got_acc = m_access;
                break;
            end
            run_len = m_access ? run_len + 1 : 0;
            @(posedge clk);
            lat++;
            #1;
            start = inj && (lat == 5);
            if (start) begin
                src = 30'h0ABC; dst = 30'h0DEF; len = 16'd9;
            end
        end
        if (!(got_done || got_err)) chk(1'b0, "end_timeout", lat, 0);
        @(posedge clk);
        #1 active = 1'b0;
    endtask

    task automatic do_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l,
                           input int wr_wait, input int ww_wait, input bit commit, input bit inj);
        for (int i = 0; i < int'(l); i++) begin
            logic [AW-1:0] a, b;
            logic [31:0]   v;
            a = s + AW'(i);
            b = d + AW'(i);
            v = mdl_rd(a);
            exp_q.push_back('{1'b0, a, 32'h0});
            exp_q.push_back('{1'b1, b, v});
            if (commit) mdl[b] = v;
        end
        wait_rd = wr_wait;
        wait_wr = ww_wait;
        @(posedge clk);
        #1;
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        active = 1'b1;
        wait_end(inj);
    endtask

    task automatic chk_dst(input logic [AW-1:0] d, input int l);
        for (int i = 0; i < l; i++)
            chk(ram_rd(d + AW'(i)) == mdl_rd(d + AW'(i)), "ram_vs_model", ram_rd(d + AW'(i)), mdl_rd(d + AW'(i)));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({busy, done, error, m_access, m_cs, m_wr_en, m_bytesel, m_wr_val} == 0 && m_addr == 0,
            "reset_outputs", {m_wr_val, m_bytesel, busy, done, error, m_access, m_cs, m_wr_en}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Boot-style copy of four known ROM words.
        for (int i = 0; i < 4; i++) begin
            ram[30'h10 + AW'(i)] = 32'hA0 + i;
            mdl[30'h10 + AW'(i)] = 32'hA0 + i;
        end
        n_rd = 0; n_wr = 0;
        do_copy(30'h10, 30'h200, 16'd4, 0, 0, 1'b1, 1'b0);
        chk(got_done && !got_err, "len4_done", {got_done, got_err}, 2'b10);
        chk(lat == 24, "len4_latency", lat, 24);
        chk(exp_q.size() == 0, "len4_all_txns", exp_q.size(), 0);
        chk(n_rd == 4 && n_wr == 4, "len4_txn_count", {n_rd[15:0], n_wr[15:0]}, {16'd4, 16'd4});
        for (int i = 0; i < 4; i++)
            chk(ram_rd(30'h200 + AW'(i)) == 32'hA0 + i, "len4_ram", ram_rd(30'h200 + AW'(i)), 32'hA0 + i);

        // Zero-length copy finishes at once without touching the bus.
        n_rd = 0; n_wr = 0;
        do_copy(30'h40, 30'h240, 16'd0, 0, 0, 1'b1, 1'b0);
        chk(got_done && lat == 0, "len0_done_now", {got_done, lat[7:0]}, {1'b1, 8'd0});
        chk(n_rd + n_wr == 0, "len0_no_access", n_rd + n_wr, 0);

        // Acks while idle must be ignored.
        spur = 1'b1;
        repeat (10) @(posedge clk);
        #1 spur = 1'b0;
        repeat (3) @(posedge clk);
        chk(n_rd + n_wr == 0 && !busy, "idle_ack_ignored", {n_rd[7:0], busy}, 0);

        // Slow responder, with re-acks landing in the gap cycles.
        do_copy(30'h300, 30'h400, 16'd3, 5, 5, 1'b1, 1'b0);
        chk(got_done && exp_q.size() == 0, "wait5_done", {got_done, exp_q.size()}, 1);
        chk_dst(30'h400, 3);

        // Read ack arriving on the very limit cycle still completes.
        do_copy(30'h500, 30'h600, 16'd1, TO - 2, 0, 1'b1, 1'b0);
        chk(got_done && !got_err, "ack_on_limit", {got_done, got_err}, 2'b10);
        chk_dst(30'h600, 1);

        // Write never acked: abort after TIMEOUT request cycles.
        do_copy(30'h700, 30'h800, 16'd3, 0, -1, 1'b0, 1'b0);
        chk(got_err && !got_done, "stuck_error", {got_err, got_done}, 2'b10);
        chk(run_len == TO, "stuck_req_cycles", run_len, TO);
        chk(!got_acc, "stuck_access_low", got_acc, 0);
        chk(exp_q.size() == 5, "stuck_pending", exp_q.size(), 5);
        chk(!ram.exists(30'h800), "stuck_ram_untouched", ram.exists(30'h800), 0);
        exp_q.delete();

        // Address wrap, with a start pulse during busy that must be ignored.
        rd_log.delete();
        do_copy(30'h3FFFFFFF, 30'h900, 16'd2, 0, 0, 1'b1, 1'b1);
        chk(got_done && exp_q.size() == 0, "wrap_done", {got_done, exp_q.size()}, 1);
        chk(rd_log.size() == 2 && rd_log[0] == 30'h3FFFFFFF && rd_log[1] == 30'h0, "wrap_read_addrs",
            {rd_log.size() > 1 ? rd_log[1] : 30'h3, rd_log.size() > 0 ? rd_log[0] : 30'h3}, {30'h0, 30'h3FFFFFFF});
        chk_dst(30'h900, 2);

        // Reset while a write is outstanding.
        wait_rd = 0; wait_wr = 3;
        exp_q.push_back('{1'b0, 30'hA00, 32'h0});
        @(posedge clk);
        #1;
        src = 30'hA00; dst = 30'hB00; len = 16'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; active = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                seen = m_access && m_wr_en;
            end
            chk(seen, "reach_wr_req", seen, 1);
        end
        #2 rst_n = 1'b0;
        active = 1'b0;
        #1;
        chk({busy, done, error, m_access, m_cs, m_wr_en, m_bytesel, m_wr_val} == 0 && m_addr == 0,
            "midreset_outputs", {m_wr_val, m_bytesel, busy, done, error, m_access, m_cs, m_wr_en}, 0);
        chk(exp_q.size() == 0, "midreset_read_done", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        do_copy(30'hC00, 30'hD00, 16'd3, 0, 0, 1'b1, 1'b0);
        chk(got_done && exp_q.size() == 0, "post_reset_copy", {got_done, exp_q.size()}, 1);
        chk_dst(30'hD00, 3);

        // Randomized copies against the model.
        for (int k = 0; k < 10; k++) begin
            logic [AW-1:0] s, d;
            logic [LW-1:0] l;
            s = AW'($urandom);
            d = AW'($urandom);
            l = LW'($urandom_range(1, 6));
            do_copy(s, d, l, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b1, 1'b0);
            chk(got_done && !got_err && exp_q.size() == 0, "rand_copy", {got_done, got_err, exp_q.size()}, 64'h2 << 32);
            chk_dst(d, int'(l));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
